// File: rtl/uart_autobaud_if.sv
// ----------------------------------------------------------------------------
// uart_autobaud_if
//   Bundles the configuration/status signals of uart_autobaud.
//   master : drives enable and rx, observes the measurement results.
//   slave  : the autobaud block itself.
// Signals:
//   enable          0 forces the detector idle
//   rx              raw asynchronous UART line, idle high
//   cfg_counter_div last good divider value
//   valid           one-cycle pulse on a divider update
//   locked          sticky after the first good measurement
//   err             one-cycle pulse on a rejected measurement
//   err_code        1 tolerance, 2 timeout, 3 too short; held until next err
//   busy            high while a measurement is in progress
// ----------------------------------------------------------------------------
interface uart_autobaud_if #(
    parameter int COUNTER_BITS = 16
) ();
    logic                    enable;
    logic                    rx;
    logic [COUNTER_BITS-1:0] cfg_counter_div;
    logic                    valid;
    logic                    locked;
    logic                    err;
    logic [1:0]              err_code;
    logic                    busy;

    modport master (
        output enable, rx,
        input  cfg_counter_div, valid, locked, err, err_code, busy
    );

    modport slave (
        input  enable, rx,
        output cfg_counter_div, valid, locked, err, err_code, busy
    );
endinterface

// File: rtl/uart_autobaud.sv
// ----------------------------------------------------------------------------
// uart_autobaud
//   Measures the bit period of a 0x55 sync character on a UART line and turns
//   it into the cfg_counter_div value of uart_divider (strobe period is
//   cfg_counter_div+2 clocks).
//
//   The start fall opens the measurement; the following 8 alternating edges
//   close 8 segments. Segment 0 (start bit) is the reference; every later
//   segment must be within +/- L0/4 of it. The 8th edge lies 8 bit times
//   after the start fall, giving D = ((T+4)>>3) - 2, clamped to the output
//   range.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    uart_autobaud_if.slave (enable, rx in; results out)
//
// Optional build macro:
//   UART_AUTOBAUD_GLITCH_FILTER_EN  inserts a 3-tap majority filter after the
//   synchronizer (+2 cycles on every edge, pulses of 1 cycle suppressed).
// ----------------------------------------------------------------------------
module uart_autobaud #(
    parameter int COUNTER_BITS = 16,
    parameter int MIN_BIT_CLKS = 4,
    parameter int DEFAULT_DIV  = 868
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_autobaud_if.slave bus
);
    localparam int SEG_W = COUNTER_BITS + 1;
    // Eight segments, each below 2^SEG_W, plus the +4 rounding term.
    localparam int TOT_W = COUNTER_BITS + 5;

    localparam logic [SEG_W-1:0]        SEG_MAX = '1;
    localparam logic [SEG_W-1:0]        MIN_SEG = SEG_W'(MIN_BIT_CLKS);
    localparam logic [COUNTER_BITS-1:0] DEF_DIV = COUNTER_BITS'(DEFAULT_DIV);
    localparam logic [TOT_W-1:0]        DIV_MAX =
        {{(TOT_W-COUNTER_BITS){1'b0}}, {COUNTER_BITS{1'b1}}};

    typedef enum logic [1:0] {
        WAIT_HIGH,
        ARMED,
        MEASURE
    } state_e;

    // ------------------------------------------------------------------
    // rx synchronizer (and optional majority filter)
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_sync_q;
    logic rs;
    logic rs_prev_q;

    // NOTE: sequential state is always written with <= so every flop samples
    // the pre-edge value of its neighbours; a blocking = here would collapse
    // the two synchronizer stages into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_sync_q <= rx_meta_q;
        end
    end

`ifdef UART_AUTOBAUD_GLITCH_FILTER_EN
    logic [1:0] tap_q;
    logic       rs_filt_q;

    // Majority over the current and two previous synced samples, registered:
    // a clean step reaches rs two cycles later, a lone 1-cycle pulse never
    // wins the vote.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_q     <= 2'b11;
            rs_filt_q <= 1'b1;
        end else begin
            tap_q     <= {tap_q[0], rx_sync_q};
            rs_filt_q <= (rx_sync_q & tap_q[0]) | (rx_sync_q & tap_q[1]) |
                         (tap_q[0] & tap_q[1]);
        end
    end

    assign rs = rs_filt_q;
`else
    assign rs = rx_sync_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_prev_q <= 1'b1;
        end else begin
            rs_prev_q <= rs;
        end
    end

    logic rs_edge;
    logic rs_fall;

    assign rs_edge = rs ^ rs_prev_q;
    assign rs_fall = rs_prev_q & ~rs;

    // ------------------------------------------------------------------
    // Measurement datapath helpers
    // ------------------------------------------------------------------
    state_e                  state_q;
    logic [SEG_W-1:0]        seg_q;
    logic [SEG_W-1:0]        l0_q;
    logic [TOT_W-1:0]        tot_q;
    logic [2:0]              idx_q;
    logic [COUNTER_BITS-1:0] div_q;
    logic                    valid_q;
    logic                    locked_q;
    logic                    err_q;
    logic [1:0]              err_code_q;
    logic                    busy_q;

    logic [SEG_W-1:0]        seg_diff;
    logic                    in_tol;
    logic [TOT_W-1:0]        quot;
    logic [COUNTER_BITS-1:0] div_d;

    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        seg_diff = '0;
        in_tol   = 1'b0;
        quot     = '0;
        div_d    = '0;

        seg_diff = (seg_q >= l0_q) ? (seg_q - l0_q) : (l0_q - seg_q);
        in_tol   = (seg_diff <= (l0_q >> 2));

        // tot_q holds T (start fall to 8th edge) in the edge cycle.
        quot = (tot_q + TOT_W'(4)) >> 3;
        if (quot < TOT_W'(2)) begin
            div_d = '0;
        end else if ((quot - TOT_W'(2)) > DIV_MAX) begin
            div_d = '1;
        end else begin
            div_d = COUNTER_BITS'(quot - TOT_W'(2));
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT_HIGH;
            seg_q      <= '0;
            l0_q       <= '0;
            tot_q      <= '0;
            idx_q      <= '0;
            div_q      <= DEF_DIV;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
            busy_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;

            if (!bus.enable) begin
                state_q <= WAIT_HIGH;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    WAIT_HIGH: begin
                        if (rs) begin
                            state_q <= ARMED;
                        end
                    end

                    ARMED: begin
                        if (rs_fall) begin
                            // The fall cycle itself is the first cycle of
                            // the start bit, so both counters start at 1.
                            state_q <= MEASURE;
                            busy_q  <= 1'b1;
                            seg_q   <= SEG_W'(1);
                            tot_q   <= TOT_W'(1);
                            idx_q   <= '0;
                        end
                    end

                    MEASURE: begin
                        seg_q <= seg_q + SEG_W'(1);
                        tot_q <= tot_q + TOT_W'(1);

                        if (rs_edge) begin
                            // seg_q is the length of the segment this edge
                            // closes; the edge cycle opens the next one.
                            seg_q <= SEG_W'(1);
                            if (idx_q == 3'd0) begin
                                if (seg_q < MIN_SEG) begin
                                    err_q      <= 1'b1;
                                    err_code_q <= 2'd3;
                                    busy_q     <= 1'b0;
                                    state_q    <= WAIT_HIGH;
                                end else begin
                                    l0_q  <= seg_q;
                                    idx_q <= 3'd1;
                                end
                            end else if (!in_tol) begin
                                err_q      <= 1'b1;
                                err_code_q <= 2'd1;
                                busy_q     <= 1'b0;
                                state_q    <= WAIT_HIGH;
                            end else if (idx_q == 3'd7) begin
                                div_q    <= div_d;
                                valid_q  <= 1'b1;
                                locked_q <= 1'b1;
                                busy_q   <= 1'b0;
                                state_q  <= WAIT_HIGH;
                            end else begin
                                idx_q <= idx_q + 3'd1;
                            end
                        end else if (seg_q == SEG_MAX) begin
                            err_q      <= 1'b1;
                            err_code_q <= 2'd2;
                            busy_q     <= 1'b0;
                            state_q    <= WAIT_HIGH;
                        end
                    end

                    default: begin
                        state_q <= WAIT_HIGH;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.cfg_counter_div = div_q;
    assign bus.valid           = valid_q;
    assign bus.locked          = locked_q;
    assign bus.err             = err_q;
    assign bus.err_code        = err_code_q;
    assign bus.busy            = busy_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// ----------------------------------------------------------------------------
// tb_uart_autobaud
//   Drives 'U' frames (described as lists of line-segment lengths after the
//   start fall) into two uart_autobaud instances (16-bit and 8-bit divider)
//   and compares every valid/err pulse against an edge-list reference model.
// ----------------------------------------------------------------------------
module tb_uart_autobaud;
    localparam int MIN_BIT = 4;
`ifdef UART_AUTOBAUD_GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    typedef int iq_t[$];

    typedef struct {
        int dut;
        int kind;   // 0 valid, 1 err
        int code;
        int cyc;
        int div;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   busy_before = 0;
    int   busy_after = 0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_autobaud_if #(.COUNTER_BITS(16)) bus0 ();
    uart_autobaud_if #(.COUNTER_BITS(8))  bus1 ();

    uart_autobaud #(.COUNTER_BITS(16), .MIN_BIT_CLKS(4), .DEFAULT_DIV(868)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    uart_autobaud #(.COUNTER_BITS(8), .MIN_BIT_CLKS(4), .DEFAULT_DIV(200)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // Event monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus0.valid === 1'b1) obs_q.push_back('{0, 0, 0, cyc, int'(bus0.cfg_counter_div)});
            if (bus0.err   === 1'b1) obs_q.push_back('{0, 1, int'(bus0.err_code), cyc, 0});
            if (bus1.valid === 1'b1) obs_q.push_back('{1, 0, 0, cyc, int'(bus1.cfg_counter_div)});
            if (bus1.err   === 1'b1) obs_q.push_back('{1, 1, int'(bus1.err_code), cyc, 0});
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, observed cycle %0d required < 90000", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int dut, input logic v);
        if (dut == 0) bus0.rx = v;
        else          bus1.rx = v;
    endtask

    function automatic iq_t u_frame(input int p);
        iq_t q;
        for (int k = 0; k < 9; k++) q.push_back(p);
        return q;
    endfunction

    function automatic int div_of(input int t, input int cb);
        int d;
        d = ((t + 4) >> 3) - 2;
        if (d < 0) d = 0;
        if (d > (1 << cb) - 1) d = (1 << cb) - 1;
        return d;
    endfunction

    // Reference model: walks the edges of the line. Piece k is low for even
    // k (ends in a rise), high for odd k (ends in a fall). After a decision
    // the detector re-arms and the next fall starts a fresh measurement.
    function automatic void model(input int dut, input int cb, input int s0, input iq_t pin);
        iq_t p;
        int  k, t, idx, l0, tot, diff;
        bit  meas;
        k = 0;
`ifdef UART_AUTOBAUD_GLITCH_FILTER_EN
        while (k < pin.size()) begin
            if (pin[k] == 1 && p.size() > 0 && k + 1 < pin.size()) begin
                p[p.size()-1] = p[p.size()-1] + 1 + pin[k+1];
                k += 2;
            end else begin
                p.push_back(pin[k]);
                k++;
            end
        end
`else
        p = pin;
`endif
        t = s0; meas = 1'b1; idx = 0; l0 = 0; tot = 0;
        for (int i = 0; i < p.size(); i++) begin
            t += p[i];
            if (i == p.size() - 1 && (i % 2) == 1) break;
            if (meas) begin
                tot += p[i];
                if (idx == 0) begin
                    if (p[i] < MIN_BIT) begin
                        exp_q.push_back('{dut, 1, 3, t + LAT, 0});
                        meas = 1'b0;
                    end else begin
                        l0 = p[i];
                    end
                end else begin
                    diff = p[i] - l0;
                    if (diff < 0) diff = -diff;
                    if (diff > l0 / 4) begin
                        exp_q.push_back('{dut, 1, 1, t + LAT, 0});
                        meas = 1'b0;
                    end
                end
                if (meas) begin
                    idx++;
                    if (idx == 8) begin
                        exp_q.push_back('{dut, 0, 0, t + LAT, div_of(tot, cb)});
                        meas = 1'b0;
                    end
                end
            end else if ((i % 2) == 1) begin
                meas = 1'b1; idx = 0; tot = 0;
            end
        end
    endfunction

    task automatic send(input int dut, input iq_t pieces, input int drop_at, output int s0);
        int lvl;
        set_rx(dut, 1'b1);
        repeat (8) tick();
        tick();
        s0 = cyc;
        lvl = 0;
        set_rx(dut, 1'b0);
        for (int k = 0; k < pieces.size(); k++) begin
            for (int j = 1; j <= pieces[k]; j++) begin
                tick();
                if (drop_at >= 0 && cyc - s0 == drop_at) begin
                    busy_before = int'(bus0.busy);
                    bus0.enable = 1'b0;
                end
                if (drop_at >= 0 && cyc - s0 == drop_at + 1) busy_after = int'(bus0.busy);
                if (j == pieces[k]) begin
                    lvl = (k == pieces.size() - 1) ? 1 : 1 - lvl;
                    set_rx(dut, lvl[0]);
                end
            end
        end
        repeat (30) tick();
        bus0.enable = 1'b0;
        bus1.enable = 1'b0;
        tick();
        tick();
        bus0.enable = 1'b1;
        bus1.enable = 1'b1;
        tick();
    endtask

    task automatic run_frame(input string tag, input int dut, input iq_t pieces, input int drop_at);
        int s0;
        exp_q.delete();
        obs_q.delete();
        send(dut, pieces, drop_at, s0);
        if (drop_at < 0) model(dut, (dut == 0) ? 16 : 8, s0, pieces);
        check({tag, ".events"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) begin
                check($sformatf("%s.ev%0d.dut", tag, i),  obs_q[i].dut,  exp_q[i].dut);
                check($sformatf("%s.ev%0d.kind", tag, i), obs_q[i].kind, exp_q[i].kind);
                check($sformatf("%s.ev%0d.code", tag, i), obs_q[i].code, exp_q[i].code);
                check($sformatf("%s.ev%0d.cyc", tag, i),  obs_q[i].cyc,  exp_q[i].cyc);
                check($sformatf("%s.ev%0d.div", tag, i),  obs_q[i].div,  exp_q[i].div);
            end
        end
    endtask

    task automatic random_frames();
        iq_t pc;
        int  p, j, d, v;
        for (int f = 0; f < 16; f++) begin
            pc.delete();
            d = ($urandom_range(0, 3) == 0) ? 1 : 0;
            p = int'($urandom_range(4, 120));
            case ($urandom_range(0, 2))
                0:       j = 0;
                1:       j = p / 8;
                default: j = p / 3;
            endcase
            for (int k = 0; k < 9; k++) begin
                v = p + int'($urandom_range(0, 2 * j)) - j;
                if (v < 2) v = 2;
                pc.push_back(v);
            end
            run_frame($sformatf("rnd%0d", f), d, pc, -1);
        end
    endtask

    task automatic timeout_test();
        int s0, waited;
        obs_q.delete();
        bus1.rx = 1'b1;
        repeat (8) tick();
        tick();
        s0 = cyc;
        bus1.rx = 1'b0;
        waited = 0;
        while (obs_q.size() == 0 && waited < 700) begin
            @(negedge clk);
            waited++;
        end
        #1;
        check("tmo.events", obs_q.size(), 1);
        if (obs_q.size() > 0) begin
            check("tmo.kind", obs_q[0].kind, 1);
            check("tmo.code", obs_q[0].code, 2);
            check("tmo.cyc",  obs_q[0].cyc, s0 + LAT + 511);
        end
        check("tmo.busy",   bus1.busy, 0);
        check("tmo.code_o", bus1.err_code, 2);
        check("tmo.div",    bus1.cfg_counter_div, 255);
        check("tmo.locked", bus1.locked, 1);
        bus1.rx = 1'b1;
        repeat (10) tick();
    endtask

    initial begin
        iq_t pc;
        bus0.enable = 1'b1; bus0.rx = 1'b1;
        bus1.enable = 1'b1; bus1.rx = 1'b1;
        repeat (3) tick();
        check("rst.div0",   bus0.cfg_counter_div, 868);
        check("rst.div1",   bus1.cfg_counter_div, 200);
        check("rst.valid",  bus0.valid, 0);
        check("rst.locked", bus0.locked, 0);
        check("rst.err",    bus0.err, 0);
        check("rst.code",   bus0.err_code, 0);
        check("rst.busy",   bus0.busy, 0);
        rst_n = 1'b1;
        repeat (5) tick();
        check("post_rst.div", bus0.cfg_counter_div, 868);

        run_frame("u100", 0, u_frame(100), -1);
        check("u100.div",    bus0.cfg_counter_div, 98);
        check("u100.locked", bus0.locked, 1);

        run_frame("u104", 0, u_frame(104), -1);
        check("u104.div", bus0.cfg_counter_div, 102);
        run_frame("u37", 0, u_frame(37), -1);
        check("u37.div", bus0.cfg_counter_div, 35);

        pc = u_frame(100);
        pc[3] = 130;
        run_frame("stretch", 0, pc, -1);
        check("stretch.div",  bus0.cfg_counter_div, 35);
        check("stretch.code", bus0.err_code, 1);

        run_frame("short", 0, u_frame(3), -1);
        check("short.code", bus0.err_code, 3);

        run_frame("drop", 0, u_frame(100), 350);
        check("drop.busy_before", busy_before, 1);
        check("drop.busy_after",  busy_after, 0);
        check("drop.code_held",   bus0.err_code, 3);
        check("drop.div_held",    bus0.cfg_counter_div, 35);

        pc = '{100, 100, 100, 50, 1, 49, 100, 100, 100, 100, 100};
        run_frame("glitch", 0, pc, -1);
`ifdef UART_AUTOBAUD_GLITCH_FILTER_EN
        check("glitch.div", bus0.cfg_counter_div, 98);
`else
        check("glitch.code", bus0.err_code, 1);
        check("glitch.div",  bus0.cfg_counter_div, 35);
`endif

        run_frame("clamp", 1, u_frame(300), -1);
        check("clamp.div",    bus1.cfg_counter_div, 255);
        check("clamp.locked", bus1.locked, 1);

        timeout_test();
        random_frames();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
